// File: rtl/apb_pkg.sv
// Shared APB types: FSM state encoding, default bus widths and the requester command record.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master.sv
// APB initiator: one command at a time through SETUP/ACCESS; APB_MASTER_TIMEOUT_EN adds an ACCESS abort.
// Latency: accept at edge N, response pulse in cycle N+3 plus one cycle per wait state.
// Backpressure: cmd_ready only in IDLE; the response is a single pulse that cannot be stalled.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  apb_state_e        state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rdy_q, rdy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              accept;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
  logic             timeout;

  // Abort on the TIMEOUT_CYCLES-th ACCESS cycle that still sees no PREADY.
  assign timeout = (state_q == APB_ACCESS) && !PREADY &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 1);
`endif

  assign accept = (state_q == APB_IDLE) && cmd_valid && rdy_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      APB_IDLE: begin
        if (accept) begin
          state_d = APB_SETUP;
          cmd_d   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
        end
      end
      APB_SETUP: begin
        state_d = APB_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      APB_ACCESS: begin
        if (PREADY) begin
          state_d     = APB_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = cmd_q.write ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (timeout) begin
          state_d     = APB_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d       = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = APB_IDLE;
    endcase

    // Bus controls come straight from flops so PSEL/PENABLE never glitch.
    psel_d    = (state_d != APB_IDLE);
    penable_d = (state_d == APB_ACCESS);
    rdy_d     = (state_d == APB_IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= APB_IDLE;
      cmd_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rdy_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = rdy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = cmd_q.write;
  assign PADDR     = cmd_q.addr;
  assign PWDATA    = cmd_q.wdata;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level reference model checked every cycle plus directed scenarios.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK      = 1'b0;
  logic          PRESETn   = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          PREADY    = 1'b0;
  logic [DW-1:0] PRDATA    = '0;

  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is "busy" from acceptance until its response,
  // m_age counts cycles since acceptance (1 = setup, >=2 = access phase).
  logic          m_busy  = 1'b0;
  logic          m_rsp_v = 1'b0;
  logic          m_err   = 1'b0;
  logic          m_ready = 1'b0;
  logic          m_wr    = 1'b0;
  int            m_age   = 0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_pwrite", PWRITE, 0);
      m_busy = 1'b0; m_rsp_v = 1'b0; m_err = 1'b0; m_wr = 1'b0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_ready = 1'b1;
    end else begin
      chk("m_psel", PSEL, m_busy);
      chk("m_penable", PENABLE, m_busy && (m_age >= 2));
      chk("m_cmd_ready", cmd_ready, m_ready);
      chk("m_rsp_valid", rsp_valid, m_rsp_v);
      chk("m_rsp_rdata", rsp_rdata, m_rdata);
      chk("m_rsp_err", rsp_err, m_err);
      chk("m_paddr", PADDR, m_addr);
      chk("m_pwrite", PWRITE, m_wr);
      chk("m_pwdata", PWDATA, m_wdata);
      m_rsp_v = 1'b0;
      if (!m_busy) begin
        if (cmd_valid && m_ready) begin
          m_busy = 1'b1; m_age = 1;
          m_wr = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (PREADY) begin
        m_busy = 1'b0; m_rsp_v = 1'b1; m_err = 1'b0;
        m_rdata = m_wr ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
      end else if (m_age - 1 == TO) begin
        m_busy = 1'b0; m_rsp_v = 1'b1; m_err = 1'b1; m_rdata = '0;
`endif
      end else begin
        m_age++;
      end
      m_ready = !m_busy;
    end
  end

  // Present a command just after a posedge; returns just after the accepting edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(negedge PCLK);
    chk("issue_ready", cmd_ready, 1);
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("post_reset_ready", cmd_ready, 1);

    // Write, zero wait states
    @(posedge PCLK); #1;
    PREADY = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("t1_setup_psel", PSEL, 1);
    chk("t1_setup_penable", PENABLE, 0);
    chk("t1_setup_ready", cmd_ready, 0);
    @(negedge PCLK);
    chk("t1_access_penable", PENABLE, 1);
    chk("t1_access_pwdata", PWDATA, 32'hDEAD_BEEF);
    chk("t1_access_paddr", PADDR, 32'h10);
    chk("t1_access_pwrite", PWRITE, 1);
    @(negedge PCLK);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_rdata", rsp_rdata, 0);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_psel", PSEL, 0);
    chk("t1_rsp_ready", cmd_ready, 1);
    @(negedge PCLK);
    chk("t1_rsp_single", rsp_valid, 0);
    chk("t1_paddr_hold", PADDR, 32'h10);

    // Read, two wait states
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0020, 32'h5555_AAAA);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      chk("t2_wait_penable", PENABLE, 1);
      chk("t2_wait_paddr", PADDR, 32'h20);
      chk("t2_wait_rsp", rsp_valid, 0);
    end
    @(posedge PCLK); #1;
    PREADY = 1'b1; PRDATA = 32'h1234_5678;
    @(negedge PCLK);
    chk("t2_last_penable", PENABLE, 1);
    @(negedge PCLK);
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_rdata", rsp_rdata, 32'h1234_5678);
    @(posedge PCLK); #1;
    PRDATA = 32'h0BAD_0BAD;
    @(negedge PCLK);
    chk("t2_rdata_hold", rsp_rdata, 32'h1234_5678);

    // Back-to-back writes with cmd_valid held
    @(posedge PCLK); #1;
    issue(1'b1, 32'h0000_0030, 32'h1111_1111);
    cmd_addr = 32'h0000_0034; cmd_wdata = 32'h2222_2222;
    @(negedge PCLK);
    chk("t3_busy_ready", cmd_ready, 0);
    @(negedge PCLK);
    chk("t3_first_paddr", PADDR, 32'h30);
    @(negedge PCLK);
    chk("t3_gap_psel", PSEL, 0);
    chk("t3_gap_rsp", rsp_valid, 1);
    chk("t3_gap_ready", cmd_ready, 1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("t3_second_psel", PSEL, 1);
    chk("t3_second_penable", PENABLE, 0);
    chk("t3_second_paddr", PADDR, 32'h34);
    chk("t3_second_pwdata", PWDATA, 32'h2222_2222);
    repeat (2) @(negedge PCLK);
    chk("t3_second_rsp", rsp_valid, 1);

    // Reset in the middle of ACCESS
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0040, 32'h0);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("t4_pre_penable", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("t4_async_psel", PSEL, 0);
    chk("t4_async_penable", PENABLE, 0);
    chk("t4_async_rsp", rsp_valid, 0);
    chk("t4_async_ready", cmd_ready, 0);
    @(negedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("t4_release_ready", cmd_ready, 1);
    chk("t4_release_rsp", rsp_valid, 0);
    repeat (3) @(negedge PCLK);
    chk("t4_no_stray_rsp", rsp_valid, 0);

`ifdef APB_MASTER_TIMEOUT_EN
    // PREADY arrives in the last allowed ACCESS cycle
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0050, 32'h0);
    cmd_valid = 1'b0;
    repeat (4) @(negedge PCLK);
    @(posedge PCLK); #1;
    PREADY = 1'b1; PRDATA = 32'hCAFE_0001;
    @(negedge PCLK);
    chk("t6_edge_penable", PENABLE, 1);
    @(negedge PCLK);
    chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_rsp_err", rsp_err, 0);
    chk("t6_rsp_rdata", rsp_rdata, 32'hCAFE_0001);

    // PREADY stuck low: abort after four ACCESS cycles
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0060, 32'h0);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    for (int i = 0; i < TO; i++) begin
      @(negedge PCLK);
      chk("t5_access_penable", PENABLE, 1);
      chk("t5_access_rsp", rsp_valid, 0);
    end
    @(negedge PCLK);
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_err", rsp_err, 1);
    chk("t5_rsp_rdata", rsp_rdata, 0);
    chk("t5_psel_drop", PSEL, 0);
    chk("t5_penable_drop", PENABLE, 0);
    @(negedge PCLK);
    chk("t5_rsp_single", rsp_valid, 0);
    chk("t5_err_hold", rsp_err, 1);
`else
    // Long wait never aborts
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0060, 32'h0);
    cmd_valid = 1'b0;
    repeat (8) @(negedge PCLK);
    chk("t5_still_waiting", PENABLE, 1);
    chk("t5_no_rsp", rsp_valid, 0);
    @(posedge PCLK); #1;
    PREADY = 1'b1; PRDATA = 32'hCAFE_0002;
    repeat (2) @(negedge PCLK);
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_err", rsp_err, 0);
    chk("t5_rsp_rdata", rsp_rdata, 32'hCAFE_0002);
`endif

    repeat (2) @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator: turns single-beat commands from a local requester (bridge front end or CPU-side sequencer) into APB SETUP/ACCESS transfers.
- Drives one APB slave segment: PSEL, PENABLE, PWRITE, PADDR, PWDATA.
- Returns read data and completion status to the requester on a one-cycle response pulse.
- One transfer outstanding at a time; no pipelining across transfers.

Parameters:
- ADDR_W, 32, address width of cmd_addr and PADDR.
- DATA_W, 32, data width of cmd_wdata, PWDATA, PRDATA and rsp_rdata.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles before abort. Used only when APB_MASTER_TIMEOUT_EN is defined; must be >= 1.

Ports:
- PCLK  in  1  APB clock; all logic on posedge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  requester has a command.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_W  slave read data.

Behaviour:
- Reset: PRESETn is asynchronous, active-low; clock is PCLK. While PRESETn is low, the FSM is in IDLE and every output is 0, including cmd_ready, which is 0 during reset only. Reset asserted mid-transfer drops PSEL and PENABLE immediately; no response is generated.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1; PSEL = 0; PENABLE = 0.
  - On cmd_valid && cmd_ready at an edge: latch cmd_write, cmd_addr, cmd_wdata into PWRITE, PADDR, PWDATA; go to SETUP.
- SETUP:
  - PSEL = 1, PENABLE = 0; cmd_ready = 0.
  - Always go to ACCESS next cycle.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE and PWDATA stay stable from SETUP until the transfer ends.
  - If PREADY = 1 at the edge: sample PRDATA into rsp_rdata (reads only; writes load 0), pulse rsp_valid for the next cycle with rsp_err = 0, go to IDLE.
  - If PREADY = 0: stay in ACCESS.
- Latency: command accepted at edge N → SETUP in cycle N+1 → ACCESS in cycle N+2. With zero wait states, rsp_valid is high in cycle N+3 and cmd_ready is high again in N+3. Minimum issue interval is 3 cycles; each wait state adds 1 cycle.
- Output timing:
  - rsp_valid is high for exactly one cycle per accepted command; there is no backpressure on the response.
  - rsp_rdata and rsp_err hold their values until the next response.
- PSEL and PENABLE are registered outputs, glitch-free. PSEL drops to 0 for at least one cycle (IDLE) between transfers.
- When PSEL = 0, PADDR, PWRITE and PWDATA hold their last values. They are not zeroed between transfers.
- cmd_valid while not in IDLE is ignored; the requester must hold it until cmd_ready.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts: go to IDLE, deassert PSEL and PENABLE, pulse rsp_valid with rsp_err = 1 and rsp_rdata = 0.
  - PREADY = 1 in the same cycle as the limit is a normal completion; PREADY wins.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err is tied to 0.

Decomposition:
- Shared package apb_pkg:
  - State typedef apb_state_e {APB_IDLE, APB_SETUP, APB_ACCESS}.
  - Default widths APB_ADDR_W = 32 and APB_DATA_W = 32.
  - Command struct apb_cmd_t {write, addr, wdata}.
- No sub-module: the FSM and the optional counter stay in one module.

Test Plan:
- Write with zero wait: cmd write addr 0x0000_0010, wdata 0xDEAD_BEEF, PREADY = 1 → SETUP cycle with PSEL = 1, PENABLE = 0; ACCESS with PWDATA = 0xDEAD_BEEF, PADDR = 0x10; rsp_valid 3 cycles after accept; rsp_rdata = 0, rsp_err = 0.
- Read with 2 wait states: PREADY low for 2 ACCESS cycles, then high with PRDATA = 0x1234_5678 → PADDR and PENABLE stable throughout; rsp_valid at accept+5; rsp_rdata = 0x1234_5678.
- Back-to-back: cmd_valid held high with 2 commands queued → PSEL low for exactly 1 cycle between transfers; second accept in the cycle rsp_valid pulses for the first.
- Reset mid-ACCESS: PRESETn low while PENABLE = 1 → PSEL, PENABLE and rsp_valid go to 0 asynchronously; after release, cmd_ready = 1 and no stray rsp_valid.
- Timeout (macro defined, TIMEOUT_CYCLES = 4): PREADY stuck at 0 → exactly 4 ACCESS cycles, then rsp_valid with rsp_err = 1 and rsp_rdata = 0; PSEL = 0 in the following cycle.
- Timeout boundary: PREADY rises in the 4th ACCESS cycle → rsp_err = 0 and PRDATA is captured.
